// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;
  logic           fits;

  // quo doubles as the dividend shift register; its MSB is the next bit to bring down
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, divisor};
  assign fits      = (rem_shift >= {1'b0, divisor});
  assign rem_next  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers for the execute stage.
//   state  | meaning
//   IDLE   | waiting for start; MTHI/MTLO writes accepted
//   CALC   | one multiply/divide bit per cycle, WIDTH cycles
//   FINISH | sign-correct, write HI/LO, pulse done
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  mdu_state_e       state, state_nx;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [CNT_W-1:0] cnt;
  logic             sa, sb, op_div, div_zero;

  logic             in_div, in_signed, a_neg, b_neg, launch;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             neg_res;

  assign in_div    = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
  assign in_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign a_neg     = in_signed && a_i[WIDTH-1];
  assign b_neg     = in_signed && b_i[WIDTH-1];
  assign a_mag     = a_neg ? (~a_i + WIDTH'(1)) : a_i;
  assign b_mag     = b_neg ? (~b_i + WIDTH'(1)) : b_i;
  assign launch    = (state == IDLE) && start_i && !flush_i;

  // Shift-add multiply: acc_lo starts as the multiplier and is consumed LSB first
  assign mul_add = acc_lo[0] ? opnd : '0;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, mul_add};

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .rem      (acc_hi),
    .quo      (acc_lo),
    .divisor  (opnd),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Divide-by-zero needs only LO forced; the remainder path already rebuilds a_i
  assign neg_res  = sa ^ sb;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? (~prod + PW'(1)) : prod;
  assign quo_fix  = div_zero ? '1 : (neg_res ? (~acc_lo + WIDTH'(1)) : acc_lo);
  assign rem_fix  = sa ? (~acc_hi + WIDTH'(1)) : acc_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i && !flush_i) state_nx = CALC;
      CALC: begin
        if (flush_i)                          state_nx = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))    state_nx = FINISH;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (launch) begin
            sa       <= a_neg;
            sb       <= b_neg;
            op_div   <= in_div;
            div_zero <= in_div && (b_i == '0);
            acc_hi   <= '0;
            acc_lo   <= in_div ? a_mag : b_mag;
            opnd     <= in_div ? b_mag : a_mag;
            cnt      <= '0;
          end
        end
        CALC: begin
          if (!flush_i) begin
            cnt <= cnt + CNT_W'(1);
            if (op_div) begin
              acc_hi <= rem_next;
              acc_lo <= quo_next;
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end
          end
        end
        FINISH: begin
          if (!flush_i) begin
            if (op_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[PW-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == FINISH) && !flush_i;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
